// File: rtl/fp_add_pkg.sv
// Shared constants and helpers for the binary64/binary32 adder.
// Exponent values are carried as 14-bit signed so wrap and tiny checks stay exact.
package fp_add_pkg;

    localparam int unsigned EXP_W_D = 11;
    localparam int unsigned EXP_W_S = 8;
    localparam int unsigned BIAS_D  = 1023;
    localparam int unsigned BIAS_S  = 127;

    localparam logic signed [13:0] EMAX_D = 14'sd2046;
    localparam logic signed [13:0] EMAX_S = 14'sd254;
    localparam logic signed [13:0] WRAP_D = 14'sd1536;
    localparam logic signed [13:0] WRAP_S = 14'sd192;

    localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] QNAN_S = 32'h7FC0_0000;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RZ  = 3'b001,
        RM_RU  = 3'b010,
        RM_RD  = 3'b011
    } rm_e;

    function automatic rm_e rm_decode(logic [2:0] rm);
        return rm[2] ? RM_RNE : rm_e'(rm);
    endfunction

    function automatic logic [63:0] inf_val(logic s, logic sp);
        return sp ? {s, 8'hFF, 55'd0} : {s, 11'h7FF, 52'd0};
    endfunction

    function automatic logic [63:0] max_val(logic s, logic sp);
        return sp ? {s, 8'hFE, 23'h7FFFFF, 32'd0}
                  : {s, 11'h7FE, {52{1'b1}}};
    endfunction

endpackage

// File: rtl/fp_add_if.sv
// Operand/result bundle between the FPU execute stage and fp_add.
// Single-precision values live in bits [63:32].
interface fp_add_if;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  rm;
    logic [2:0]  op_type;
    logic        P;
    logic        OvEn;
    logic        UnEn;
    logic [63:0] result;
    logic [4:0]  Flags;
    logic        Denorm;
    logic [4:0]  flags_acc;

    modport master (
        output op1, op2, rm, op_type, P, OvEn, UnEn,
        input  result, Flags, Denorm, flags_acc
    );

    modport slave (
        input  op1, op2, rm, op_type, P, OvEn, UnEn,
        output result, Flags, Denorm, flags_acc
    );
endinterface

// File: rtl/fp_round.sv
// Rounds a right-aligned significand (53 or 24 bits) using G/R/S.
// A carry out of the top bit renormalizes to 1.0 and bumps the exponent.
module fp_round
    import fp_add_pkg::*;
(
    input  logic               sign_i,
    input  logic               prec_i,
    input  rm_e                rm_i,
    input  logic signed [13:0] exp_i,
    input  logic [52:0]        sig_i,
    input  logic               g_i,
    input  logic               r_i,
    input  logic               s_i,
    output logic [52:0]        sig_o,
    output logic signed [13:0] exp_o,
    output logic               carry_o,
    output logic               inexact_o
);

    logic        inc;
    logic [53:0] sum;

    always_comb begin
        inexact_o = g_i | r_i | s_i;
        inc       = 1'b0;
        unique case (rm_i)
            RM_RNE:  inc = g_i & (r_i | s_i | sig_i[0]);
            RM_RZ:   inc = 1'b0;
            RM_RU:   inc = inexact_o & ~sign_i;
            RM_RD:   inc = inexact_o & sign_i;
            default: inc = 1'b0;
        endcase
        sum     = {1'b0, sig_i} + 54'(inc);
        carry_o = prec_i ? sum[24] : sum[53];
        sig_o   = sum[52:0];
        exp_o   = exp_i;
        if (carry_o) begin
            sig_o = prec_i ? (53'd1 << 23) : (53'd1 << 52);
            exp_o = exp_i + 14'sd1;
        end
    end

endmodule

// File: rtl/fp_add.sv
// IEEE 754 binary64/binary32 add/sub: unpack, align, add, normalize, pack.
// Datapath is combinational; only the accrued flag register is clocked.
module fp_add
    import fp_add_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    fp_add_if.slave io
);

    logic               sp, sa, sb, s1, s2, eff_sub;
    logic [10:0]        ea_f, eb_f, eall, ea, eb, e1, e2, d, lim;
    logic [51:0]        fa, fb;
    logic               nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
    logic [52:0]        ma, mb, m1, m2, sig, rsig;
    logic [5:0]         sh, lz, shamt;
    logic [54:0]        ext2, sext, lostm;
    logic [55:0]        a56, b56, n56;
    logic [56:0]        sum;
    logic signed [13:0] e_n, e_r, emax, wrap, ev;
    logic               g, r, s, nx_r, carry, hidden;
    logic               zero_sum, tiny, ovf, to_inf, nv;
    logic [63:0]        qa, qb, qnan, res;
    logic [4:0]         flags, flags_acc_d, flags_acc_q;
    logic               denorm;
    rm_e                rmode;
    logic               unused_bits;

    always_comb begin
        sp    = io.P;
        rmode = rm_decode(io.rm);
        sa    = io.op1[63];
        sb    = io.op2[63] ^ io.op_type[0];
        if (sp) begin
            ea_f = {3'b000, io.op1[62:55]};
            eb_f = {3'b000, io.op2[62:55]};
            fa   = {io.op1[54:32], 29'd0};
            fb   = {io.op2[54:32], 29'd0};
            eall = 11'd255;
            qa   = {io.op1[63:55], 1'b1, io.op1[53:32], 32'd0};
            qb   = {io.op2[63:55], 1'b1, io.op2[53:32], 32'd0};
            qnan = {QNAN_S, 32'd0};
            emax = EMAX_S;
            wrap = WRAP_S;
        end else begin
            ea_f = io.op1[62:52];
            eb_f = io.op2[62:52];
            fa   = io.op1[51:0];
            fb   = io.op2[51:0];
            eall = 11'h7FF;
            qa   = {io.op1[63:52], 1'b1, io.op1[50:0]};
            qb   = {io.op2[63:52], 1'b1, io.op2[50:0]};
            qnan = QNAN_D;
            emax = EMAX_D;
            wrap = WRAP_D;
        end
        nan_a  = (ea_f == eall) && (fa != 52'd0);
        nan_b  = (eb_f == eall) && (fb != 52'd0);
        inf_a  = (ea_f == eall) && (fa == 52'd0);
        inf_b  = (eb_f == eall) && (fb == 52'd0);
        snan_a = nan_a && !fa[51];
        snan_b = nan_b && !fb[51];
        // subnormals: hidden bit 0, exponent treated as 1
        ma = {(ea_f != 11'd0), fa};
        mb = {(eb_f != 11'd0), fb};
        ea = (ea_f == 11'd0) ? 11'd1 : ea_f;
        eb = (eb_f == 11'd0) ? 11'd1 : eb_f;

        if ({ea, ma} >= {eb, mb}) begin
            s1 = sa; e1 = ea; m1 = ma;
            s2 = sb; e2 = eb; m2 = mb;
        end else begin
            s1 = sb; e1 = eb; m1 = mb;
            s2 = sa; e2 = ea; m2 = ma;
        end
        eff_sub  = s1 ^ s2;
        d        = e1 - e2;
        sh       = (d > 11'd55) ? 6'd55 : d[5:0];
        ext2     = {m2, 2'b00};
        sext     = ext2 >> sh;
        lostm    = ext2 & ~({55{1'b1}} << sh);
        a56      = {m1, 3'b000};
        b56      = {sext, |lostm};
        sum      = eff_sub ? ({1'b0, a56} - {1'b0, b56})
                           : ({1'b0, a56} + {1'b0, b56});
        zero_sum = (sum == 57'd0);

        lz = 6'd56;
        for (int i = 0; i < 56; i++)
            if (sum[i]) lz = 6'(55 - i);
        // without an underflow trap the shift stops at the minimum exponent
        lim   = e1 - 11'd1;
        shamt = lz;
        if (!io.UnEn && ({5'd0, lz} > lim)) shamt = lim[5:0];
        if (sum[56]) begin
            n56 = {sum[56:2], sum[1] | sum[0]};
            e_n = $signed({3'b000, e1}) + 14'sd1;
        end else begin
            n56 = sum[55:0] << shamt;
            e_n = $signed({3'b000, e1}) - $signed({8'd0, shamt});
        end

        if (sp) begin
            sig = {29'd0, n56[55:32]};
            g   = n56[31];
            r   = n56[30];
            s   = |n56[29:0];
        end else begin
            sig = n56[55:3];
            g   = n56[2];
            r   = n56[1];
            s   = n56[0];
        end
    end

    fp_round u_round (
        .sign_i    (s1),
        .prec_i    (sp),
        .rm_i      (rmode),
        .exp_i     (e_n),
        .sig_i     (sig),
        .g_i       (g),
        .r_i       (r),
        .s_i       (s),
        .sig_o     (rsig),
        .exp_o     (e_r),
        .carry_o   (carry),
        .inexact_o (nx_r)
    );

    always_comb begin
        hidden = sp ? rsig[23] : rsig[52];
        tiny   = !zero_sum && ((e_r < 14'sd1) || !hidden);
        ovf    = !zero_sum && (e_r > emax);
        to_inf = (rmode == RM_RNE) || ((rmode == RM_RU) && !s1)
              || ((rmode == RM_RD) && s1);
        if (ovf && io.OvEn)       ev = e_r - wrap;
        else if (tiny && io.UnEn) ev = e_r + wrap;
        else if (!hidden)         ev = 14'sd0;
        else                      ev = e_r;
        res = sp ? {s1, ev[7:0], rsig[22:0], 32'd0}
                 : {s1, ev[10:0], rsig[51:0]};
        flags         = 5'd0;
        flags[FLG_OF] = ovf;
        flags[FLG_UF] = io.UnEn ? tiny : (tiny && nx_r);
        flags[FLG_NX] = nx_r || ovf;
        if (ovf && !io.OvEn)
            res = to_inf ? inf_val(s1, sp) : max_val(s1, sp);
        if (zero_sum) begin
            res   = {(eff_sub ? (rmode == RM_RD) : s1), 63'd0};
            flags = 5'd0;
        end
        nv = snan_a || snan_b || (inf_a && inf_b && eff_sub);
        if (nan_a || nan_b || inf_a || inf_b) begin
            flags         = 5'd0;
            flags[FLG_NV] = nv;
            if (nan_a)                         res = qa;
            else if (nan_b)                    res = qb;
            else if (inf_a && inf_b && eff_sub) res = qnan;
            else if (inf_a)                    res = inf_val(sa, sp);
            else                               res = inf_val(sb, sp);
        end
        denorm = sp ? ((res[62:55] == 8'd0) && (res[54:32] != 23'd0))
                    : ((res[62:52] == 11'd0) && (res[51:0] != 52'd0));
    end

    assign flags_acc_d = flags_acc_q | flags;

    always_ff @(posedge clk) begin
        if (!reset) flags_acc_q <= 5'd0;
        else        flags_acc_q <= flags_acc_d;
    end

    assign io.result    = res;
    assign io.Flags     = flags;
    assign io.Denorm    = denorm;
    assign io.flags_acc = flags_acc_q;
    assign unused_bits  = ^{io.op_type[2:1], ev[13:11], carry};

endmodule

// File: tb/tb_fp_add.sv
// Directed-vector scoreboard bench for fp_add.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_fp_add;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fp_add_if io ();

    fp_add dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    typedef struct {
        string       nm;
        logic [63:0] r;
        logic [4:0]  f;
        logic        dn;
        logic        ca;
        logic [4:0]  acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (io.result !== mon_e.r) begin
                errors++;
                $display("FAIL %s result got %h want %h", mon_e.nm, io.result, mon_e.r);
            end
            checks++;
            if (io.Flags !== mon_e.f) begin
                errors++;
                $display("FAIL %s flags got %b want %b", mon_e.nm, io.Flags, mon_e.f);
            end
            checks++;
            if (io.Denorm !== mon_e.dn) begin
                errors++;
                $display("FAIL %s denorm got %b want %b", mon_e.nm, io.Denorm, mon_e.dn);
            end
            if (mon_e.ca) begin
                checks++;
                if (io.flags_acc !== mon_e.acc) begin
                    errors++;
                    $display("FAIL %s flags_acc got %b want %b", mon_e.nm, io.flags_acc, mon_e.acc);
                end
            end
        end
    end

    task automatic run(
        input string       nm,
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [2:0]  rm,
        input logic        sub,
        input logic        p,
        input logic        ov,
        input logic        un,
        input logic [63:0] r,
        input logic [4:0]  f,
        input logic        dn,
        input logic        ca,
        input logic [4:0]  acc
    );
        exp_t e;
        @(posedge clk);
        #1;
        io.op1     = a;
        io.op2     = b;
        io.rm      = rm;
        io.op_type = {2'b00, sub};
        io.P       = p;
        io.OvEn    = ov;
        io.UnEn    = un;
        e.nm  = nm;
        e.r   = r;
        e.f   = f;
        e.dn  = dn;
        e.ca  = ca;
        e.acc = acc;
        sb_q.push_back(e);
    endtask

    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] MAXP = 64'h7FEFFFFFFFFFFFFF;
    localparam logic [63:0] MAXN = 64'hFFEFFFFFFFFFFFFF;
    localparam logic [63:0] INF  = 64'h7FF0000000000000;
    localparam logic [63:0] H53  = 64'h3CA0000000000000;
    localparam logic [63:0] SONE = 64'h3F800000_00000000;
    localparam logic [63:0] SMAX = 64'h7F7FFFFF_00000000;

    initial begin
        reset      = 1'b0;
        io.op1     = '0;
        io.op2     = '0;
        io.rm      = '0;
        io.op_type = '0;
        io.P       = 1'b0;
        io.OvEn    = 1'b0;
        io.UnEn    = 1'b0;
        repeat (2) @(posedge clk);

        // sticky register sequence
        run("rst", 0, 0, 3'd0, 0, 0, 0, 0, 0, 5'b00000, 0, 1, 5'b00000);
        reset = 1'b1;
        run("ovf_ru", MAXP, MAXN, 3'd2, 1, 0, 0, 0, INF, 5'b00101, 0, 0, 0);
        run("inf_inf", INF, INF, 3'd2, 1, 0, 0, 0, 64'h7FF8000000000000, 5'b10000, 0, 1, 5'b00101);
        run("x_m_x_ru", ONE, ONE, 3'd2, 1, 0, 0, 0, 0, 5'b00000, 0, 1, 5'b10101);
        reset = 1'b0;
        run("tie_even", ONE, H53, 3'd0, 0, 0, 0, 0, ONE, 5'b00001, 0, 1, 5'b00000);
        reset = 1'b1;

        run("ru_sticky", ONE, 64'hBCA0000000000000, 3'd2, 1, 0, 0, 0, 64'h3FF0000000000001, 5'b00001, 0, 0, 0);
        run("ovf_rz", MAXP, MAXN, 3'd1, 1, 0, 0, 0, MAXP, 5'b00101, 0, 0, 0);
        run("snan", 64'h7FF0000000000001, ONE, 3'd2, 1, 0, 0, 0, 64'h7FF8000000000001, 5'b10000, 0, 0, 0);
        run("denorm", 64'h0010000000000000, 64'h000FFFFFFFFFFFFF, 3'd2, 1, 0, 0, 0, 64'h1, 5'b00000, 1, 0, 0);
        run("rd_zero", ONE, ONE, 3'd3, 1, 0, 0, 0, 64'h8000000000000000, 5'b00000, 0, 0, 0);
        run("one_p_one", ONE, ONE, 3'd0, 0, 0, 0, 0, 64'h4000000000000000, 5'b00000, 0, 0, 0);
        run("nzero", 64'h8000000000000000, 64'h8000000000000000, 3'd0, 0, 0, 0, 0, 64'h8000000000000000, 5'b00000, 0, 0, 0);
        run("rne_up", ONE, 64'h3CA8000000000000, 3'd0, 0, 0, 0, 0, 64'h3FF0000000000001, 5'b00001, 0, 0, 0);
        run("tie_odd", 64'h3FF0000000000001, H53, 3'd0, 0, 0, 0, 0, 64'h3FF0000000000002, 5'b00001, 0, 0, 0);
        run("rd_neg", 64'hBFF0000000000000, 64'hBCA0000000000000, 3'd3, 0, 0, 0, 0, 64'hBFF0000000000001, 5'b00001, 0, 0, 0);
        run("inf_fin", INF, ONE, 3'd0, 0, 0, 0, 0, INF, 5'b00000, 0, 0, 0);
        run("qnan_b", ONE, 64'hFFF8000000000005, 3'd0, 0, 0, 0, 0, 64'hFFF8000000000005, 5'b00000, 0, 0, 0);
        run("ov_trap", MAXP, MAXP, 3'd0, 0, 0, 1, 0, 64'h1FFFFFFFFFFFFFFF, 5'b00101, 0, 0, 0);
        run("un_trap", 64'h0010000000000000, 64'h000FFFFFFFFFFFFF, 3'd0, 1, 0, 0, 1, 64'h5CD0000000000000, 5'b00010, 0, 0, 0);
        run("rm_1xx", ONE, H53, 3'd6, 0, 0, 0, 0, ONE, 5'b00001, 0, 0, 0);

        run("s_add", SONE, SONE, 3'd0, 0, 1, 0, 0, 64'h40000000_00000000, 5'b00000, 0, 0, 0);
        run("s_zero", SONE, SONE, 3'd0, 1, 1, 0, 0, 0, 5'b00000, 0, 0, 0);
        run("s_ovf", SMAX, SMAX, 3'd0, 0, 1, 0, 0, 64'h7F800000_00000000, 5'b00101, 0, 0, 0);
        run("s_ovf_rz", SMAX, SMAX, 3'd1, 0, 1, 0, 0, SMAX, 5'b00101, 0, 0, 0);
        run("s_infinf", 64'h7F800000_00000000, 64'h7F800000_00000000, 3'd0, 1, 1, 0, 0, 64'h7FC00000_00000000, 5'b10000, 0, 0, 0);
        run("s_denorm", 64'h00800000_00000000, 64'h007FFFFF_00000000, 3'd0, 1, 1, 0, 0, 64'h00000001_00000000, 5'b00000, 1, 0, 0);
        run("s_ru", SONE, 64'h33800000_00000000, 3'd2, 0, 1, 0, 0, 64'h3F800001_00000000, 5'b00001, 0, 0, 0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add.md
Name: fp_add

Overview:
- IEEE 754 binary64/binary32 floating-point adder/subtractor.
- Combinational datapath: align, add/sub, normalize, round, pack; also produces exception flags and a subnormal indicator.
- Sits in the FPU execute stage.
- The clock/reset domain holds only a sticky accrued-exception register.

Parameters:
- None. Formats are fixed to binary64 and binary32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- op1  in  64  operand A
- op2  in  64  operand B
- rm  in  3  rounding mode: 000 RNE, 001 RZ, 010 RU (+inf), 011 RD (-inf), 1xx treated as RNE
- op_type  in  3  bit0: 0 = A+B, 1 = A-B; bits[2:1] ignored
- P  in  1  precision: 0 = double; 1 = single, operands in [63:32]
- OvEn  in  1  overflow trap enable
- UnEn  in  1  underflow trap enable
- result  out  64  rounded result; in single mode, result in [63:32] and [31:0]=0
- Flags  out  5  [4] invalid, [3] div-by-zero (always 0), [2] overflow, [1] underflow, [0] inexact
- Denorm  out  1  result is subnormal (nonzero, exponent field 0)
- flags_acc  out  5  sticky OR of Flags

Behaviour:
- result, Flags and Denorm are purely combinational with zero latency. They are valid within the same cycle the operands change and are not affected by reset.
- flags_acc:
  - On a clk rise with reset=0, clear to 0.
  - Otherwise flags_acc <= flags_acc | Flags.
  - Reset value 0.
- Subtract: invert op2 sign, then perform a signed-magnitude add.
- Subnormal inputs use the implicit bit 0 and exponent 1.
- Internal precision is 53-bit significand plus guard, round and sticky bits. Alignment shifts are saturated at 55+ with all shifted-out bits ORed into sticky.
- Rounding:
  - RNE: ties to even.
  - RZ: truncate.
  - RU: increment if inexact and positive.
  - RD: increment if inexact and negative.
  - A rounding carry renormalizes and bumps the exponent.
- Exact zero result:
  - Sign is +0 for x+(-x), except RD gives -0.
  - (-0)+(-0) = -0.
- Overflow (unbounded exponent > max):
  - Set overflow and inexact.
  - Result is inf or max-finite according to rm and sign. Example: RU positive -> +inf, RU negative -> -max.
  - If OvEn=1: return the exponent-wrapped value instead (exponent minus 1536 for double, 192 for single) and do not saturate.
- Underflow:
  - Tiny is detected after rounding.
  - Untrapped (UnEn=0): flag only when the result is tiny and inexact.
  - Trapped (UnEn=1): flag when tiny; exponent plus 1536/192 wrap.
- NaN and infinity:
  - Any sNaN input: set invalid.
  - inf - inf (effective subtraction): invalid, result is the canonical qNaN 7FF8000000000000 (single 7FC00000).
  - Otherwise, a NaN input propagates quieted, with op1 having priority.
  - inf ± finite gives inf with no flags.
- Denorm = 1 iff the packed result is a nonzero subnormal.
- Single mode applies the same rules with 24-bit significand, 8-bit exponent and bias 127.

Decomposition:
- Package fp_add_pkg:
  - Format constants: exponent widths, biases, wrap offsets.
  - Canonical NaN constants.
  - rm encoding enum.
  - Flag bit index localparams.
- One sub-module fp_round: takes sign, exponent, significand, G/R/S and rm; returns the rounded significand, exponent carry and inexact.
- Top level handles unpack, align, add, leading-zero normalize, specials and pack.

Test Plan:
- rm=010, sub, 3FF0000000000000 - 3FF0000000000000 -> 0000000000000000, Flags 00000.
- rm=010, sub, 3FF0000000000000 - BCA0000000000000 -> 3FF0000000000001, Flags 00001.
- rm=010, sub, 7FEFFFFFFFFFFFFF - FFEFFFFFFFFFFFFF -> 7FF0000000000000, Flags 00101. Same operands with rm=001 -> 7FEFFFFFFFFFFFFF.
- rm=010, sub, 7FF0000000000000 - 7FF0000000000000 -> 7FF8000000000000, Flags 10000. sNaN 7FF0000000000001 - 1.0 -> 7FF8000000000001, Flags 10000.
- rm=010, sub, 0010000000000000 - 000FFFFFFFFFFFFF -> 0000000000000001, Denorm=1, Flags 00000. rm=011, 1.0 - 1.0 -> 8000000000000000.
- Sticky register:
  - Apply the overflow case for one cycle; flags_acc reads 00101 afterwards.
  - Apply the invalid case; flags_acc reads 10101.
  - Drive reset=0 for one clk edge; flags_acc reads 00000.
